pool_window_gen: RTL and testbench
==================================

Name: pool_window_gen

Overview:
- Sliding KxK window generator for the second convolution stage.
- Consumes the gated pooled pixel stream of one layer-1 channel: `pool_out` / `valid`, 14x14 raster order, 9-bit signed.
- Presents a full 5x5 neighbourhood as one flat bus to the layer-2 MAC.
- One instance per layer-1 channel (six total). Line buffers decouple the bursty pooled stream from the window consumer.

Parameters:
- PP, 8: MSB index of pixel (pixel width PP+1, signed).
- W, 14: input map width (pixels per row).
- H, 14: input map height (rows per frame).
- K, 5: window size (KxK).

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- pxl_in  input  PP+1  signed pooled pixel, raster order.
- in_valid  input  1  pxl_in is accepted this cycle; connects to upstream valid.
- window_out  output  K*K*(PP+1)  flattened window.
- valid  output  1  window_out holds a complete, legal window.
- frame_done  output  1  one-cycle pulse with the last window of a frame.

Behaviour:
- Reset (reset high at a posedge):
  - col=0, row=0.
  - window registers, window_out, valid and frame_done all 0.
  - Line-buffer contents need not clear; valid gating makes stale data unobservable.
  - Reset applied mid-frame abandons the frame; the next accepted pixel is treated as (0,0).
- Accept:
  - Each posedge with in_valid=1 and reset=0 accepts one pixel at (row, col).
  - col increments and wraps W-1 -> 0; on that wrap row increments.
  - row wraps H-1 -> 0, so the next frame follows back-to-back with no idle cycle required.
- Storage:
  - K-1 line buffers, each W deep, form a shift chain. The column entering the window is {lb[K-2][col], ..., lb[0][col], pxl_in} (oldest row first).
  - On accept, the KxK window register shifts left one column and loads that new column at c=K-1.
  - On accept, the line buffers update at index col.
  - All buffers and counters hold when in_valid=0.
- Window layout:
  - Element (r,c), r=0 oldest row, c=0 leftmost, sits at index i=r*K+c.
  - Element i occupies bits [(i+1)*(PP+1)-1 : i*(PP+1)].
  - Values are passed unmodified; no arithmetic, sign preserved.
- Output timing:
  - valid=1 on the cycle after accepting pixel (row,col) iff row>=K-1 and col>=K-1.
  - window_out updates in that same cycle; latency is 1 cycle from the accept edge.
  - valid is otherwise 0, including any cycle after in_valid=0.
  - window_out holds its last value when valid=0.
- frame_done = valid for the pixel (H-1, W-1).
- Windows per frame = (W-K+1)*(H-K+1) = 100 at defaults. Windows never straddle a row wrap; col>=K-1 guarantees this.
- Simultaneous reset and in_valid: reset wins and the pixel is dropped.

Test Plan:
1. Continuous frame, pxl_in = row*14+col, in_valid=1 for 196 cycles:
   - First valid comes one cycle after the 61st pixel, with window[0]=0, window[4]=4, window[20]=56, window[24]=60.
   - Exactly 100 valid pulses.
   - frame_done exactly once, with window[24]=195 and window[0]=135.
2. Same frame with in_valid toggled 1,0,1,0 plus random 0-3 cycle gaps:
   - Window sequence and values are identical to scenario 1.
   - valid is never high in a cycle following in_valid=0.
3. Negative pixels (all pxl_in = -7, 9'h1F9) for one frame:
   - Every valid window has all 25 fields equal to 9'h1F9.
4. Reset asserted after 100 accepted pixels, then a fresh scenario-1 frame:
   - No valid pulse until the 61st post-reset pixel.
   - Values match scenario 1 exactly.
5. Two frames back-to-back with no gap, frame 2 = frame 1 + 1:
   - 200 valids and 2 frame_done pulses.
   - First window of frame 2 has window[0]=1 and window[24]=61, with no frame-1 data present.
6. reset held high with in_valid=1 for 10 cycles:
   - valid, frame_done and window_out stay 0.
   - Counters remain at (0,0).

Source files
------------

// File: rtl/pool_window_gen.sv
// Sliding KxK window generator over a raster pixel stream.
// K-1 line buffers feed a KxK shift window; legal windows are latched to window_out.
module pool_window_gen #(
   parameter int PP = 8,
   parameter int W  = 14,
   parameter int H  = 14,
   parameter int K  = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic signed [PP:0]        pxl_in,
   input  logic                      in_valid,
   output logic [K*K*(PP+1)-1:0]     window_out,
   output logic                      valid,
   output logic                      frame_done
);

   localparam int CW = $clog2(W);
   localparam int RW = $clog2(H);

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [PP:0]   lb       [K-1][W];
   logic [PP:0]   win      [K*K];
   logic [PP:0]   win_next [K*K];
   logic [PP:0]   new_col  [K];
   logic [K*K*(PP+1)-1:0] win_flat;
   logic          legal;
   logic          last_px;

   // Column entering the window: oldest row from the deepest buffer, newest from pxl_in.
   always_comb begin
      for (int unsigned r = 0; r < K; r++) begin
         new_col[r] = '0;
      end
      new_col[K-1] = pxl_in;
      for (int unsigned r = 0; r < K-1; r++) begin
         new_col[r] = lb[K-2-r][col];
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < K*K; i++) begin
         win_next[i] = '0;
      end
      for (int unsigned r = 0; r < K; r++) begin
         for (int unsigned c = 0; c < K-1; c++) begin
            win_next[r*K+c] = win[r*K+c+1];
         end
         win_next[r*K+K-1] = new_col[r];
      end
   end

   always_comb begin
      win_flat = '0;
      for (int unsigned i = 0; i < K*K; i++) begin
         win_flat[i*(PP+1) +: (PP+1)] = win_next[i];
      end
   end

   assign legal   = (row >= RW'(K-1)) && (col >= CW'(K-1));
   assign last_px = (row == RW'(H-1)) && (col == CW'(W-1));

   // Line buffers carry no reset; stale contents are masked by the legal-window gating.
   always_ff @(posedge clk) begin
      if (!reset && in_valid) begin
         lb[0][col] <= pxl_in;
         for (int unsigned j = 1; j < K-1; j++) begin
            lb[j][col] <= lb[j-1][col];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col        <= '0;
         row        <= '0;
         window_out <= '0;
         valid      <= 1'b0;
         frame_done <= 1'b0;
         for (int unsigned i = 0; i < K*K; i++) begin
            win[i] <= '0;
         end
      end else if (in_valid) begin
         for (int unsigned i = 0; i < K*K; i++) begin
            win[i] <= win_next[i];
         end
         if (col == CW'(W-1)) begin
            col <= '0;
            row <= (row == RW'(H-1)) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
         valid      <= legal;
         frame_done <= legal && last_px;
         if (legal) begin
            window_out <= win_flat;
         end
      end else begin
         valid      <= 1'b0;
         frame_done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pool_window_gen.sv
// Bench for pool_window_gen: image-array reference model checked every cycle,
// plus literal expectations for the directed frames.
module tb_pool_window_gen;

   logic               clk = 1'b0;
   logic               reset;
   logic signed [8:0]  pxl_in;
   logic               in_valid;
   logic [224:0]       window_out;
   logic               valid;
   logic               frame_done;

   pool_window_gen #(.PP(8), .W(14), .H(14), .K(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .pxl_in     (pxl_in),
      .in_valid   (in_valid),
      .window_out (window_out),
      .valid      (valid),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference model: the current frame as a 2-D image, position counters
   logic signed [8:0] img [0:13][0:13];
   int                mr = 0, mc = 0, nacc = 0;
   logic              exp_valid = 1'b0, exp_fd = 1'b0, last_acc = 1'b0;
   logic [224:0]      exp_win = '0;

   // scenario bookkeeping
   bit           chk_en = 0;
   int           scen = 0;
   bit           cmpq = 0;
   logic [224:0] q1 [$];
   int           qi = 0;
   int           sc_valid = 0, sc_fd = 0, first_nacc = 0;
   bit           first_seen = 0;
   logic [224:0] first_win, fd_win, win101;

   task automatic chk(input string nm, input logic [224:0] act, input logic [224:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures < 40) $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [8:0] fld(input logic [224:0] w, input int i);
      return w[i*9 +: 9];
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         mr = 0; mc = 0; nacc = 0;
         exp_valid = 1'b0; exp_fd = 1'b0; exp_win = '0; last_acc = 1'b0;
      end else if (in_valid) begin
         last_acc = 1'b1;
         nacc++;
         img[mr][mc] = pxl_in;
         if (mr >= 4 && mc >= 4) begin
            for (int rr = 0; rr < 5; rr++)
               for (int cc = 0; cc < 5; cc++)
                  exp_win[(rr*5+cc)*9 +: 9] = img[mr-4+rr][mc-4+cc];
            exp_valid = 1'b1;
            exp_fd    = (mr == 13 && mc == 13);
         end else begin
            exp_valid = 1'b0;
            exp_fd    = 1'b0;
         end
         mc++;
         if (mc == 14) begin
            mc = 0;
            mr = (mr == 13) ? 0 : mr + 1;
         end
      end else begin
         last_acc  = 1'b0;
         exp_valid = 1'b0;
         exp_fd    = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("valid", valid, exp_valid);
         chk("frame_done", frame_done, exp_fd);
         chk("window_out", window_out, exp_win);
         if (scen == 2 && !last_acc) chk("valid_after_idle", valid, 1'b0);
         if (valid) begin
            sc_valid++;
            if (!first_seen) begin
               first_seen = 1;
               first_win  = window_out;
               first_nacc = nacc;
            end
            if (sc_valid == 101) win101 = window_out;
            if (scen == 1) q1.push_back(window_out);
            else if (cmpq) begin
               if (qi < q1.size()) chk("seq_window", window_out, q1[qi]);
               else chk("seq_overrun", 225'(qi), 225'(q1.size()));
               qi++;
            end
            if (scen == 3)
               for (int i = 0; i < 25; i++) chk("neg_field", fld(window_out, i), 9'h1F9);
         end
         if (frame_done) begin
            sc_fd++;
            fd_win = window_out;
         end
      end
   end

   task automatic clear_stats();
      sc_valid = 0; sc_fd = 0; first_seen = 0; first_nacc = 0; qi = 0;
   endtask

   task automatic send(input logic signed [8:0] v);
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b1; pxl_in = v;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0; pxl_in = 9'($urandom);
      end
   endtask

   task automatic do_reset(input int n, input bit iv);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         reset = 1'b1; in_valid = iv; pxl_in = 9'($urandom);
      end
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b0;
   endtask

   // mode: 0 ramp, 1 constant -7, 2 random values
   task automatic frame(input int base, input int mode, input bit gaps, input int npx);
      int k = 0;
      for (int r = 0; r < 14; r++)
         for (int c = 0; c < 14; c++) begin
            if (k < npx) begin
               if (mode == 1) send(-9'sd7);
               else if (mode == 2) send(9'($urandom));
               else send(9'(base + r*14 + c));
               if (gaps) idle(1 + int'($urandom_range(0, 3)));
            end
            k++;
         end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; pxl_in = '0;
      @(posedge clk);
      @(negedge clk);
      chk_en = 1;
      do_reset(2, 0);

      // 1: continuous ramp frame
      scen = 1; cmpq = 0; clear_stats();
      frame(0, 0, 0, 196); idle(2);
      chk("s1_first_at", 225'(first_nacc), 225'(61));
      chk("s1_w0",  fld(first_win, 0),  9'd0);
      chk("s1_w4",  fld(first_win, 4),  9'd4);
      chk("s1_w20", fld(first_win, 20), 9'd56);
      chk("s1_w24", fld(first_win, 24), 9'd60);
      chk("s1_nvalid", 225'(sc_valid), 225'(100));
      chk("s1_nfd", 225'(sc_fd), 225'(1));
      chk("s1_fd_w24", fld(fd_win, 24), 9'd195);
      chk("s1_fd_w0",  fld(fd_win, 0),  9'd135);

      // 2: same frame with idle gaps
      do_reset(1, 0);
      scen = 2; cmpq = 1; clear_stats();
      frame(0, 0, 1, 196); idle(2);
      chk("s2_nvalid", 225'(sc_valid), 225'(100));
      chk("s2_nfd", 225'(sc_fd), 225'(1));

      // 3: constant negative frame
      do_reset(1, 0);
      scen = 3; cmpq = 0; clear_stats();
      frame(0, 1, 0, 196); idle(2);
      chk("s3_nvalid", 225'(sc_valid), 225'(100));

      // 4: reset mid-frame, then fresh frame
      do_reset(1, 0);
      scen = 4; cmpq = 0; clear_stats();
      frame(0, 0, 0, 100);
      do_reset(1, 0);
      cmpq = 1; clear_stats();
      frame(0, 0, 0, 196); idle(2);
      chk("s4_first_at", 225'(first_nacc), 225'(61));
      chk("s4_nvalid", 225'(sc_valid), 225'(100));

      // 5: two frames back to back
      do_reset(1, 0);
      scen = 5; cmpq = 0; clear_stats();
      frame(0, 0, 0, 196);
      frame(1, 0, 0, 196); idle(2);
      chk("s5_nvalid", 225'(sc_valid), 225'(200));
      chk("s5_nfd", 225'(sc_fd), 225'(2));
      chk("s5_f2_w0",  fld(win101, 0),  9'd1);
      chk("s5_f2_w24", fld(win101, 24), 9'd61);

      // 6: reset held with in_valid high, then a frame from (0,0)
      scen = 6; cmpq = 0; clear_stats();
      do_reset(10, 1);
      chk("s6_nvalid_rst", 225'(sc_valid), 225'(0));
      chk("s6_win_rst", window_out, '0);
      cmpq = 1; clear_stats();
      frame(0, 0, 0, 196); idle(2);
      chk("s6_first_at", 225'(first_nacc), 225'(61));

      // 7: random pixels with random gaps, model-checked only
      do_reset(1, 0);
      scen = 7; cmpq = 0; clear_stats();
      frame(0, 2, 1, 196); idle(2);
      chk("s7_nvalid", 225'(sc_valid), 225'(100));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
